// File: rtl/present_key_expand_pkg.sv
// Shared PRESENT-80 key-schedule definitions: widths, S-box, FSM states and
// the single-round key update function.
package present_key_expand_pkg;

  localparam int KEY_SIZE   = 80;
  localparam int BLK_SIZE   = 64;
  localparam int NUM_ROUNDS = 31;
  localparam int RK_IDX_W   = $clog2(NUM_ROUNDS + 1);

  // PRESENT encryption S-box, indexed by the input nibble.
  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  // One step of the 80-bit key register update for round counter c.
  function automatic logic [KEY_SIZE-1:0] key_update(
    input logic [KEY_SIZE-1:0] k,
    input logic [4:0]          c
  );
    logic [KEY_SIZE-1:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = SBOX[r[79:76]];
    r[19:15]   = r[19:15] ^ c;
    return r;
  endfunction

endpackage

// File: rtl/present_key_expand_update.sv
// Combinational PRESENT-80 key update; shared by the stored-schedule expander
// and usable by an on-the-fly encrypt key path.
module present_key_update
  import present_key_expand_pkg::*;
(
  input  logic [KEY_SIZE-1:0] k,
  input  logic [4:0]          c,
  output logic [KEY_SIZE-1:0] next
);

  assign next = key_update(k, c);

endmodule

// File: rtl/present_key_expand.sv
// Sequential PRESENT-80 key schedule: one key update per cycle, all round
// keys buffered in a register file and served by index to the decryptor.
module present_key_expand
  import present_key_expand_pkg::*;
#(
  parameter int KEY_W      = KEY_SIZE,
  parameter int BLK_W      = BLK_SIZE,
  parameter int NUM_ROUNDS = present_key_expand_pkg::NUM_ROUNDS,
  parameter int IDX_W      = $clog2(NUM_ROUNDS + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             keys_valid,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [BLK_W-1:0] rd_key
);

  state_t             state;
  logic [IDX_W-1:0]   cnt;
  logic [KEY_W-1:0]   kreg;
  logic [KEY_W-1:0]   next_key;
  logic [BLK_W-1:0]   rk [0:NUM_ROUNDS];

  logic               accept;
  logic               rk_we;
  logic [IDX_W-1:0]   rk_waddr;
  logic [BLK_W-1:0]   rk_wdata;

  present_key_update u_update (
    .k    (kreg),
    .c    (cnt[4:0]),
    .next (next_key)
  );

  assign accept = (state != EXPAND) && start;

  // Select what gets written into the key buffer this cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    rk_we    = 1'b0;
    rk_waddr = '0;
    rk_wdata = next_key[KEY_W-1 -: BLK_W];
    if (accept) begin
      rk_we    = 1'b1;
      rk_waddr = '0;
      rk_wdata = key_in[KEY_W-1 -: BLK_W];
    end else if (state == EXPAND) begin
      rk_we    = 1'b1;
      rk_waddr = cnt;
    end
  end

  // Control FSM: state, round counter and registered status flags.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (start) begin
            state      <= EXPAND;
            cnt        <= IDX_W'(1);
            busy       <= 1'b1;
            keys_valid <= 1'b0;
          end
        end
        EXPAND: begin
          if (cnt == IDX_W'(NUM_ROUNDS)) begin
            state      <= READY;
            cnt        <= '0;
            busy       <= 1'b0;
            keys_valid <= 1'b1;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          busy       <= 1'b0;
          keys_valid <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: working key register and round-key buffer.
  always_ff @(posedge Clock) begin
    // NOTE: the key buffer is deliberately not reset; reads are gated by keys_valid instead.
    if (Reset) begin
      if (accept) begin
        kreg <= key_in;
      end else if (state == EXPAND) begin
        kreg <= next_key;
      end
      if (rk_we) begin
        rk[rk_waddr] <= rk_wdata;
      end
    end
  end

  // Read port: indices outside the stored range, or any read before the
  // schedule completes, return zero.
  always_comb begin
    rd_key = '0;
    if (keys_valid) begin
      for (int j = 0; j <= NUM_ROUNDS; j++) begin
        if (rd_idx == IDX_W'(j)) begin
          rd_key = rk[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_present_key_expand.sv
// Self-checking bench for present_key_expand: table of keys with known
// ciphertext/plaintext pairs, a scoreboard of modelled round keys, and
// hand-written sequences for restart, mid-expansion start and reset.
module tb_present_key_expand;

  localparam int KW = 80;
  localparam int BW = 64;
  localparam int NR = 31;
  localparam int IW = 5;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          start;
  logic [KW-1:0] key_in;
  logic          busy;
  logic          keys_valid;
  logic [IW-1:0] rd_idx;
  logic [BW-1:0] rd_key;

  int n_tests = 0;
  int n_fail  = 0;
  logic [BW-1:0] sb_q [$];

  present_key_expand dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [KW-1:0] key;
    bit            has_ct;
    logic [BW-1:0] ct;
    logic [BW-1:0] pt;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [3:0] ref_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] ref_inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'h5; 4'h1: return 4'hE; 4'h2: return 4'hF; 4'h3: return 4'h8;
      4'h4: return 4'hC; 4'h5: return 4'h1; 4'h6: return 4'h2; 4'h7: return 4'hD;
      4'h8: return 4'hB; 4'h9: return 4'h4; 4'hA: return 4'h6; 4'hB: return 4'h3;
      4'hC: return 4'h0; 4'hD: return 4'h7; 4'hE: return 4'h9; default: return 4'hA;
    endcase
  endfunction

  // Reference model: round key at buffer index j for a master key.
  function automatic logic [BW-1:0] model_rk(input logic [KW-1:0] key, input int j);
    logic [KW-1:0] k;
    logic [4:0]    c5;
    k = key;
    for (int c = 1; c <= j; c++) begin
      k        = (k << 61) | (k >> 19);
      k[79:76] = ref_sbox(k[79:76]);
      c5       = c[4:0];
      k[19:15] = k[19:15] ^ c5;
    end
    return k[79:16];
  endfunction

  // Full PRESENT decryption using round keys read from the DUT, last key first.
  task automatic decrypt(input logic [BW-1:0] ct, output logic [BW-1:0] pt);
    logic [BW-1:0] s, t;
    rd_idx = IW'(NR);
    #1;
    s = ct ^ rd_key;
    for (int r = NR - 1; r >= 0; r--) begin
      for (int i = 0; i < 63; i++) t[i] = s[(i * 16) % 63];
      t[63] = s[63];
      for (int n = 0; n < 16; n++) t[n*4 +: 4] = ref_inv_sbox(t[n*4 +: 4]);
      rd_idx = IW'(r);
      #1;
      s = t ^ rd_key;
    end
    pt = s;
  endtask

  // Start an expansion, optionally disturbing it, and compare the stored schedule.
  task automatic run_expand(input logic [KW-1:0] key, input int glitch_at, input int rst_at);
    int cyc;
    int busy_cnt;
    for (int j = 0; j <= NR; j++) sb_q.push_back(model_rk(key, j));
    key_in = key;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("valid_low_after_start", {63'd0, keys_valid}, 64'd0);
    cyc      = 0;
    busy_cnt = 0;
    while (!keys_valid && cyc < 100) begin
      if (busy) busy_cnt++;
      if (cyc == 5) check("rd_key_gated_while_busy", rd_key, 64'd0);
      if (cyc == glitch_at) begin
        start  = 1'b1;
        key_in = ~key;
      end else if (cyc == glitch_at + 1) begin
        start = 1'b0;
      end
      if (cyc == rst_at) begin
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        check("reset_mid_busy", {63'd0, busy}, 64'd0);
        check("reset_mid_valid", {63'd0, keys_valid}, 64'd0);
        check("reset_mid_rd_key", rd_key, 64'd0);
        sb_q.delete();
        return;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check("valid_latency", 64'(cyc), 64'(NR));
    check("busy_cycles", 64'(busy_cnt), 64'(NR));
    check("busy_low_when_ready", {63'd0, busy}, 64'd0);
    for (int j = 0; j <= NR; j++) begin
      rd_idx = IW'(j);
      #1;
      if (sb_q.size() == 0) begin
        check("scoreboard_underflow", 64'd1, 64'd0);
      end else begin
        check($sformatf("rk[%0d]", j), rd_key, sb_q.pop_front());
      end
    end
  endtask

  initial begin
    logic [BW-1:0] pt;
    logic [KW-1:0] key_a, key_b, key_c;

    vecs[0] = '{key: 80'h0,                    has_ct: 1'b1, ct: 64'h5579C1387B228445, pt: 64'h0};
    vecs[1] = '{key: 80'hFFFFFFFFFFFFFFFFFFFF, has_ct: 1'b1, ct: 64'hE72C46C0F5945049, pt: 64'h0};
    vecs[2] = '{key: 80'h0,                    has_ct: 1'b1, ct: 64'hA112FFC72F68417B, pt: 64'hFFFFFFFFFFFFFFFF};
    vecs[3] = '{key: 80'hFFFFFFFFFFFFFFFFFFFF, has_ct: 1'b1, ct: 64'h3333DCD3213210D2, pt: 64'hFFFFFFFFFFFFFFFF};
    vecs[4] = '{key: 80'h0123456789ABCDEF0123, has_ct: 1'b0, ct: 64'h0,                pt: 64'h0};

    Reset  = 1'b0;
    start  = 1'b0;
    key_in = '0;
    rd_idx = '0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_valid", {63'd0, keys_valid}, 64'd0);
    for (int j = 0; j <= NR; j++) begin
      rd_idx = IW'(j);
      #1;
      check("reset_rd_key", rd_key, 64'd0);
    end

    // All-zero key: first two round keys are known constants.
    run_expand(80'h0, -1, -1);
    rd_idx = 5'd0;
    #1;
    check("zero_key_rk0", rd_key, 64'h0000000000000000);
    rd_idx = 5'd1;
    #1;
    check("zero_key_rk1", rd_key, 64'hC000000000000000);

    // Table of keys with known PRESENT ciphertext/plaintext pairs.
    for (int v = 0; v < 5; v++) begin
      run_expand(vecs[v].key, -1, -1);
      if (vecs[v].has_ct) begin
        decrypt(vecs[v].ct, pt);
        check($sformatf("decrypt_vec%0d", v), pt, vecs[v].pt);
      end
    end

    // READY holds: keys stay put with no further activity.
    repeat (20) tick();
    check("ready_hold_valid", {63'd0, keys_valid}, 64'd1);
    rd_idx = IW'(NR);
    #1;
    check("ready_hold_rk31", rd_key, model_rk(vecs[4].key, NR));

    // start and key_in disturbed mid-expansion are ignored.
    key_a = 80'hA5A5_5A5A_F00F_0FF0_1234;
    run_expand(key_a, 10, -1);

    // Restart from READY with a new key.
    key_b = 80'h3C3C_C3C3_9696_6969_BEEF;
    run_expand(key_b, -1, -1);
    rd_idx = 5'd0;
    #1;
    check("restart_rk0", rd_key, key_b[79:16]);

    // Reset in the middle of an expansion, then a clean expansion.
    key_c = 80'hDEAD_BEEF_CAFE_F00D_5555;
    run_expand(key_c, -1, 15);
    tick();
    check("post_reset_idle_busy", {63'd0, busy}, 64'd0);
    run_expand(key_c, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
